// File: rtl/oam_port_ctrl_if.sv
// B-bus register port used by the CPU side of the OAM controller.
// The master drives address, strobes and write data; the slave returns read data with a valid pulse.
interface oam_port_ctrl_if;
  logic [7:0] pa_addr;
  logic       pa_wr;
  logic       pa_rd;
  logic [7:0] pa_din;
  logic [7:0] pa_dout;
  logic       pa_dout_valid;

  modport master (
    output pa_addr, pa_wr, pa_rd, pa_din,
    input  pa_dout, pa_dout_valid
  );

  modport slave (
    input  pa_addr, pa_wr, pa_rd, pa_din,
    output pa_dout, pa_dout_valid
  );
endinterface

// File: rtl/oam_port_ctrl.sv
// CPU-side OAM access controller: $2102/$2103/$2104/$2138 decode, byte pointer, low-table word pairing, high-table port A.
// Optional feature macro: OAM_PRIO_ROT_EN (priority rotation; prio_first tied to 0 when undefined).
module oam_port_ctrl (
  input  logic        clk,
  input  logic        resetn,
  oam_port_ctrl_if.slave pa,
  input  logic        vblank_start,
  input  logic        force_blank,
  input  logic        render_active,
  output logic [7:0]  loam_addr,
  output logic        loam_we,
  output logic [15:0] loam_wdata,
  input  logic [15:0] loam_rdata,
  output logic [4:0]  hoam_addr,
  output logic        hoam_we,
  output logic [7:0]  hoam_din,
  input  logic [7:0]  hoam_dout,
  output logic [6:0]  prio_first
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP} state_t;

  state_t      state_reg, state_next;
  logic        wr_acc, rd_acc, cap;
  logic        wr_02, wr_03, wr_04;
  logic [8:0]  reload_reg, reload_next;
  logic [9:0]  ptr_reg, ptr_next;
  logic [7:0]  latch_reg;
  logic        lo_we_next, hi_we_next;
  logic        rd_hi_reg, rd_byte_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Strobes are only honoured in IDLE; anything arriving mid-read is dropped.
  always_comb begin
    state_next = state_reg;
    wr_acc     = 1'b0;
    rd_acc     = 1'b0;
    cap        = 1'b0;
    case (state_reg)
      IDLE: begin
        wr_acc = pa.pa_wr;
        rd_acc = pa.pa_rd && !pa.pa_wr && (pa.pa_addr == 8'h38);
        if (rd_acc) state_next = RD_WAIT;
      end
      RD_WAIT: state_next = RD_CAP;
      RD_CAP: begin
        cap        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_02 = wr_acc && (pa.pa_addr == 8'h02);
  assign wr_03 = wr_acc && (pa.pa_addr == 8'h03);
  assign wr_04 = wr_acc && (pa.pa_addr == 8'h04);

  // A reload (register write or VBlank) overrides the post-access increment.
  always_comb begin
    reload_next = reload_reg;
    if (wr_02) reload_next[7:0] = pa.pa_din;
    if (wr_03) reload_next[8]   = pa.pa_din[0];
    ptr_next = ptr_reg;
    if (wr_04 || rd_acc) ptr_next = ptr_reg + 10'd1;
    if (wr_02 || wr_03 || (vblank_start && !force_blank)) ptr_next = {reload_next, 1'b0};
  end

  assign lo_we_next = wr_04 && !ptr_reg[9] && ptr_reg[0] && !render_active;
  assign hi_we_next = wr_04 && ptr_reg[9] && !render_active;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reload_reg    <= '0;
      ptr_reg       <= '0;
      latch_reg     <= '0;
      loam_addr     <= '0;
      loam_we       <= 1'b0;
      loam_wdata    <= '0;
      hoam_addr     <= '0;
      hoam_we       <= 1'b0;
      hoam_din      <= '0;
      rd_hi_reg     <= 1'b0;
      rd_byte_reg   <= 1'b0;
      pa.pa_dout    <= '0;
      pa.pa_dout_valid <= 1'b0;
    end else begin
      reload_reg <= reload_next;
      ptr_reg    <= ptr_next;
      loam_we    <= lo_we_next;
      hoam_we    <= hi_we_next;
      if (wr_04 && (ptr_reg[9] || !ptr_reg[0])) latch_reg <= pa.pa_din;
      if (wr_04 || rd_acc) begin
        loam_addr <= ptr_reg[8:1];
        hoam_addr <= ptr_reg[4:0];
      end
      if (lo_we_next) loam_wdata <= {pa.pa_din, latch_reg};
      if (hi_we_next) hoam_din   <= pa.pa_din;
      if (rd_acc) begin
        rd_hi_reg   <= ptr_reg[9];
        rd_byte_reg <= ptr_reg[0];
      end
      pa.pa_dout_valid <= cap;
      if (cap) begin
        if (rd_hi_reg)        pa.pa_dout <= hoam_dout;
        else if (rd_byte_reg) pa.pa_dout <= loam_rdata[15:8];
        else                  pa.pa_dout <= loam_rdata[7:0];
      end
    end
  end

`ifdef OAM_PRIO_ROT_EN
  logic prio_en_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    prio_en_reg <= 1'b0;
    else if (wr_03) prio_en_reg <= pa.pa_din[7];
  end

  assign prio_first = prio_en_reg ? reload_reg[7:1] : 7'd0;
`else
  assign prio_first = 7'd0;
`endif

endmodule

// File: tb/tb_oam_port_ctrl.sv
// Randomized self-checking bench for oam_port_ctrl against an array-based model of OAM and the pointer rules.
// Honours OAM_PRIO_ROT_EN the same way the design does.
module tb_oam_port_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        vblank_start, force_blank, render_active;
  logic [7:0]  loam_addr;
  logic        loam_we;
  logic [15:0] loam_wdata;
  logic [15:0] loam_rdata;
  logic [4:0]  hoam_addr;
  logic        hoam_we;
  logic [7:0]  hoam_din;
  logic [7:0]  hoam_dout;
  logic [6:0]  prio_first;

  always #5 clk = ~clk;

  oam_port_ctrl_if bus ();

  oam_port_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .pa           (bus),
    .vblank_start (vblank_start),
    .force_blank  (force_blank),
    .render_active(render_active),
    .loam_addr    (loam_addr),
    .loam_we      (loam_we),
    .loam_wdata   (loam_wdata),
    .loam_rdata   (loam_rdata),
    .hoam_addr    (hoam_addr),
    .hoam_we      (hoam_we),
    .hoam_din     (hoam_din),
    .hoam_dout    (hoam_dout),
    .prio_first   (prio_first)
  );

  // RAMs behind the controller, 1-cycle synchronous read
  logic [15:0] lmem [256];
  logic [7:0]  hmem [32];
  always @(posedge clk) begin
    loam_rdata <= lmem[loam_addr];
    hoam_dout  <= hmem[hoam_addr];
    if (loam_we) lmem[loam_addr] <= loam_wdata;
    if (hoam_we) hmem[hoam_addr] <= hoam_din;
  end

  // Reference model state
  int          m_ptr, m_reload, m_latch;
`ifdef OAM_PRIO_ROT_EN
  int          m_prio;
  localparam int PRIO_EXP = 'h15;
`else
  localparam int PRIO_EXP = 0;
`endif
  logic [15:0] ref_lo [256];
  logic [7:0]  ref_hi [32];

  int          checks = 0;
  int          errors = 0;
  int          lo_cnt;
  logic [7:0]  last_lo_addr;
  logic [15:0] last_lo_data;
  logic [4:0]  last_hi_addr;
  logic [7:0]  last_hi_din;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_prio();
`ifdef OAM_PRIO_ROT_EN
    return (m_prio != 0) ? (m_reload % 256) / 2 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_reload = 0; m_latch = 0;
`ifdef OAM_PRIO_ROT_EN
    m_prio = 0;
`endif
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dout"},  bus.pa_dout, 0);
    check({tag, "_valid"}, bus.pa_dout_valid, 0);
    check({tag, "_lo"},    {loam_addr, loam_we, loam_wdata}, 0);
    check({tag, "_hi"},    {hoam_addr, hoam_we, hoam_din}, 0);
    check({tag, "_prio"},  prio_first, 0);
  endtask

  // Called right after a negedge; strobe is sampled on the following posedge.
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input bit vb);
    bit exp_lo, exp_hi;
    int lo_a, hi_a, lo_d, old_ptr;
    exp_lo = 0; exp_hi = 0; lo_a = 0; hi_a = 0; lo_d = 0;
    old_ptr = m_ptr;
    case (a)
      8'h02: begin m_reload = (m_reload / 256) * 256 + d; m_ptr = m_reload * 2; end
      8'h03: begin
        m_reload = (d % 2) * 256 + m_reload % 256;
`ifdef OAM_PRIO_ROT_EN
        m_prio = d / 128;
`endif
        m_ptr = m_reload * 2;
      end
      8'h04: begin
        if (m_ptr < 512) begin
          if (m_ptr % 2 == 0) m_latch = d;
          else begin
            exp_lo = !render_active; lo_a = m_ptr / 2; lo_d = d * 256 + m_latch;
          end
        end else begin
          m_latch = d; exp_hi = !render_active; hi_a = m_ptr % 32;
        end
        m_ptr = (m_ptr + 1) % 1024;
      end
      default: ;
    endcase
    if (vb && !force_blank) m_ptr = m_reload * 2;
    if (exp_lo) ref_lo[lo_a] = lo_d[15:0];
    if (exp_hi) ref_hi[hi_a] = d;

    bus.pa_addr = a; bus.pa_din = d; bus.pa_wr = 1'b1; vblank_start = vb;
    @(negedge clk);
    bus.pa_wr = 1'b0; vblank_start = 1'b0;
    check("loam_we", loam_we, exp_lo);
    check("hoam_we", hoam_we, exp_hi);
    if (loam_we) begin lo_cnt++; last_lo_addr = loam_addr; last_lo_data = loam_wdata; end
    if (hoam_we) begin last_hi_addr = hoam_addr; last_hi_din = hoam_din; end
    if (exp_lo) begin
      check("loam_addr", loam_addr, lo_a);
      check("loam_wdata", loam_wdata, lo_d);
    end
    if (exp_hi) begin
      check("hoam_addr", hoam_addr, hi_a);
      check("hoam_din", hoam_din, d);
    end
    check("prio_first", prio_first, exp_prio());
    @(negedge clk);
    check("we_pulse_len", {loam_we, hoam_we}, 0);
    $display("WR addr=%02h data=%02h vb=%0d ra=%0d ptr %03h->%03h", a, d, vb, render_active, old_ptr, m_ptr);
  endtask

  task automatic bus_read(input bit junk, input bit vb, output logic [7:0] val);
    logic [15:0] w;
    logic [7:0]  exp;
    int          old_ptr;
    bit          hi;
    old_ptr = m_ptr;
    hi = (m_ptr >= 512);
    w = ref_lo[(m_ptr / 2) % 256];
    if (hi)                exp = ref_hi[m_ptr % 32];
    else if (m_ptr % 2)    exp = w[15:8];
    else                   exp = w[7:0];
    m_ptr = (m_ptr + 1) % 1024;
    if (vb && !force_blank) m_ptr = m_reload * 2;

    bus.pa_addr = 8'h38; bus.pa_rd = 1'b1; vblank_start = vb;
    @(negedge clk);
    bus.pa_rd = 1'b0; vblank_start = 1'b0;
    if (hi) check("rd_hoam_addr", hoam_addr, old_ptr % 32);
    else    check("rd_loam_addr", loam_addr, (old_ptr / 2) % 256);
    check("rd_valid_n1", bus.pa_dout_valid, 0);
    if (junk) begin bus.pa_addr = 8'h02; bus.pa_din = 8'hFF; bus.pa_wr = 1'b1; end
    @(negedge clk);
    check("rd_valid_n2", bus.pa_dout_valid, 0);
    bus.pa_wr = 1'b0;
    if (junk) begin bus.pa_addr = 8'h38; bus.pa_rd = 1'b1; end
    @(negedge clk);
    bus.pa_rd = 1'b0;
    check("rd_valid_n3", bus.pa_dout_valid, 1);
    check("rd_dout", bus.pa_dout, exp);
    val = bus.pa_dout;
    $display("RD ptr=%03h data=%02h junk=%0d vb=%0d", old_ptr, bus.pa_dout, junk, vb);
  endtask

  task automatic nop_read(input logic [7:0] a);
    bus.pa_addr = a; bus.pa_rd = 1'b1;
    @(negedge clk);
    bus.pa_rd = 1'b0;
    repeat (3) begin
      check("nop_valid", bus.pa_dout_valid, 0);
      @(negedge clk);
    end
    $display("RD-undecoded addr=%02h", a);
  endtask

  task automatic pulse_vblank(input bit fb);
    force_blank = fb; vblank_start = 1'b1;
    @(negedge clk);
    vblank_start = 1'b0;
    if (!fb) m_ptr = m_reload * 2;
    $display("VB force_blank=%0d ptr=%03h", fb, m_ptr);
  endtask

  task automatic abort_read();
    bus.pa_addr = 8'h38; bus.pa_rd = 1'b1;
    @(negedge clk);
    bus.pa_rd = 1'b0;
    resetn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_valid", bus.pa_dout_valid, 0);
    end
    check_outputs_zero("abort_rst");
    resetn = 1'b1;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("abort_valid_after", bus.pa_dout_valid, 0);
    end
    $display("RESET during read");
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] a;
    int         op;
    resetn = 1'b0;
    bus.pa_addr = '0; bus.pa_din = '0; bus.pa_wr = 1'b0; bus.pa_rd = 1'b0;
    vblank_start = 1'b0; force_blank = 1'b0; render_active = 1'b0;
    lo_cnt = 0; last_lo_addr = '0; last_lo_data = '0; last_hi_addr = '0; last_hi_din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    resetn = 1'b1;
    @(negedge clk);

    // Fill both tables through the controller so model and RAM agree
    bus_write(8'h02, 8'h00, 0);
    bus_write(8'h03, 8'h00, 0);
    for (int i = 0; i < 512; i++) bus_write(8'h04, 8'($urandom), 0);
    bus_write(8'h03, 8'h01, 0);
    bus_write(8'h02, 8'h00, 0);
    for (int i = 0; i < 32; i++) bus_write(8'h04, 8'($urandom), 0);

    // Word pairing
    bus_write(8'h02, 8'h10, 0);
    bus_write(8'h03, 8'h00, 0);
    lo_cnt = 0;
    bus_write(8'h04, 8'hAA, 0);
    bus_write(8'h04, 8'hBB, 0);
    check("pair_cnt", lo_cnt, 1);
    check("pair_addr", last_lo_addr, 8'h10);
    check("pair_data", last_lo_data, 16'hBBAA);
    bus_read(0, 0, r);

    // High table with mirror
    bus_write(8'h03, 8'h01, 0);
    bus_write(8'h02, 8'h00, 0);
    for (int i = 0; i <= 32; i++) bus_write(8'h04, 8'(i), 0);
    check("mirror_addr", last_hi_addr, 5'd0);
    check("mirror_din", last_hi_din, 8'd32);

    // Read path
    bus_write(8'h03, 8'h00, 0);
    bus_write(8'h02, 8'h05, 0);
    bus_write(8'h04, 8'h34, 0);
    bus_write(8'h04, 8'h12, 0);
    bus_write(8'h02, 8'h05, 0);
    bus_read(0, 0, r);
    check("rd_path_lo", r, 8'h34);
    bus_read(0, 0, r);
    check("rd_path_hi", r, 8'h12);
    bus_read(0, 0, r);

    // Wrap and reload
    bus_write(8'h03, 8'h01, 0);
    bus_write(8'h02, 8'hFF, 0);
    bus_write(8'h04, 8'h5A, 0);
    bus_write(8'h04, 8'hA5, 0);
    bus_read(0, 0, r);
    pulse_vblank(0);
    bus_read(0, 0, r);
    check("wrap_reload_rd", r, 8'h5A);
    pulse_vblank(1);
    bus_read(0, 0, r);
    check("wrap_noreload_rd", r, 8'hA5);

    // Render lockout
    bus_write(8'h03, 8'h00, 0);
    bus_write(8'h02, 8'h20, 0);
    render_active = 1'b1;
    lo_cnt = 0;
    bus_write(8'h04, 8'h11, 0);
    bus_write(8'h04, 8'h22, 0);
    check("lock_cnt", lo_cnt, 0);
    render_active = 1'b0;
    bus_write(8'h04, 8'h33, 0);
    bus_write(8'h04, 8'h44, 0);
    check("lock_cnt_after", lo_cnt, 1);
    check("lock_addr", last_lo_addr, 8'h21);

    // Simultaneous access and reload
    force_blank = 1'b0;
    bus_write(8'h02, 8'h30, 0);
    bus_write(8'h04, 8'h77, 1);
    bus_write(8'h04, 8'h66, 0);
    bus_write(8'h04, 8'h55, 0);
    bus_read(1, 1, r);
    bus_read(1, 0, r);

    // Priority
    bus_write(8'h02, 8'h2A, 0);
    bus_write(8'h03, 8'h80, 0);
    check("prio_value", prio_first, PRIO_EXP);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      render_active = ($urandom_range(0, 5) == 0);
      force_blank   = ($urandom_range(0, 2) == 0);
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: bus_write(8'h04, 8'($urandom), ($urandom_range(0, 15) == 0));
        4: bus_write(8'h02, 8'($urandom), 0);
        5: bus_write(8'h03, 8'($urandom), 0);
        6: begin
          a = 8'($urandom);
          if (a >= 8'h02 && a <= 8'h04) a = 8'h38;
          bus_write(a, 8'($urandom), 0);
        end
        7, 8: bus_read($urandom_range(0, 1) == 1, ($urandom_range(0, 15) == 0), r);
        default: begin
          if ($urandom_range(0, 1) == 1) pulse_vblank($urandom_range(0, 1) == 1);
          else nop_read(8'h39);
        end
      endcase
    end
    render_active = 1'b0;
    force_blank = 1'b0;

    // Reset during RD_WAIT
    bus_write(8'h02, 8'h03, 0);
    abort_read();
    bus_read(0, 0, r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
